// File: rtl/spi_rx_word_writer_if.sv
// Request port between the SPI word writer (master) and the SPI DMA bridge (slave).
// The writer issues single-word writes and the bridge answers each one with a rdy pulse.
interface spi_rx_word_writer_if;
    logic [31:0] addr;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic        rdy;

    modport master (output addr, output write, output writedata, output read, input rdy);
    modport slave  (input addr, input write, input writedata, input read, output rdy);
endinterface

// File: rtl/spi_rx_word_writer.sv
// Packs received SPI bytes into 32-bit little-endian words and writes them to consecutive
// addresses through the DMA bridge, one request per word, with a one-word hold buffer.
module spi_rx_word_writer #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [31:0]          base_addr,
    input  logic [CNT_W-1:0]     word_count,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    spi_rx_word_writer_if.master dma,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [CNT_W-1:0]     words_written
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        REQ   = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_r;
    logic [31:0]      cur_addr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] words_packed_r;
    logic [CNT_W-1:0] ww_r;
    logic [1:0]       byte_cnt_r;
    logic [23:0]      pack_r;
    logic [31:0]      hold_r;
    logic             hold_valid_r;
    logic             abort_pend_r;
    logic [31:0]      addr_r;
    logic [31:0]      wdata_r;
    logic             write_r;
    logic             busy_r;
    logic             done_r;
    logic             ovf_r;

    assign dma.addr      = addr_r;
    assign dma.write     = write_r;
    assign dma.writedata = wdata_r;
    assign dma.read      = 1'b0;
    assign busy          = busy_r;
    assign done          = done_r;
    assign overflow      = ovf_r;
    assign words_written = ww_r;

    // Byte packer, hold buffer and request sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            cur_addr_r     <= 32'd0;
            count_r        <= '0;
            words_packed_r <= '0;
            ww_r           <= '0;
            byte_cnt_r     <= 2'd0;
            pack_r         <= 24'd0;
            hold_r         <= 32'd0;
            hold_valid_r   <= 1'b0;
            abort_pend_r   <= 1'b0;
            addr_r         <= 32'd0;
            wdata_r        <= 32'd0;
            write_r        <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            ovf_r          <= 1'b0;
        end else begin
            done_r  <= 1'b0;
            write_r <= 1'b0;

            // A full hold on the 4th byte drops the byte and leaves 3 bytes packed.
            if (busy_r && (words_packed_r < count_r) && rx_valid) begin
                if (byte_cnt_r != 2'd3) begin
                    case (byte_cnt_r)
                        2'd0:    pack_r[7:0]   <= rx_data;
                        2'd1:    pack_r[15:8]  <= rx_data;
                        2'd2:    pack_r[23:16] <= rx_data;
                        default: pack_r        <= pack_r;
                    endcase
                    byte_cnt_r <= byte_cnt_r + 2'd1;
                end else if (!hold_valid_r) begin
                    hold_r         <= {rx_data, pack_r};
                    hold_valid_r   <= 1'b1;
                    byte_cnt_r     <= 2'd0;
                    words_packed_r <= words_packed_r + CNT_W'(1);
                end else begin
                    ovf_r <= 1'b1;
                end
            end

            case (state_r)
                IDLE: begin
                    if (start) begin
                        cur_addr_r     <= base_addr;
                        count_r        <= word_count;
                        ww_r           <= '0;
                        words_packed_r <= '0;
                        ovf_r          <= 1'b0;
                        byte_cnt_r     <= 2'd0;
                        pack_r         <= 24'd0;
                        hold_valid_r   <= 1'b0;
                        abort_pend_r   <= 1'b0;
                        busy_r         <= 1'b1;
                        state_r        <= (word_count == '0) ? DONE : ARMED;
                    end
                end
                ARMED: begin
                    if (hold_valid_r) begin
                        wdata_r      <= hold_r;
                        addr_r       <= cur_addr_r;
                        hold_valid_r <= 1'b0;
                        write_r      <= 1'b1;
                        abort_pend_r <= abort;
                        state_r      <= REQ;
                    end else if (abort) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (abort) begin
                        abort_pend_r <= 1'b1;
                    end
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (abort) begin
                        abort_pend_r <= 1'b1;
                    end
                    // The bridge cannot cancel, so abort only takes effect after rdy.
                    if (dma.rdy) begin
                        ww_r       <= ww_r + CNT_W'(1);
                        cur_addr_r <= cur_addr_r + 32'd4;
                        if (abort_pend_r || abort) begin
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end else if ((ww_r + CNT_W'(1)) == count_r) begin
                            state_r <= DONE;
                        end else begin
                            state_r <= ARMED;
                        end
                    end
                end
                DONE: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
